// File: rtl/opb_register_simulink2ppc_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_simulink2ppc_fifo_if
// Brief    : OPB bus bundle between a master and the simulink2ppc FIFO slave.
// Revision : 1.0 - initial release
// ============================================================================
interface opb_register_simulink2ppc_fifo_if;
   logic [0:31] OPB_ABus;
   logic [0:3]  OPB_BE;
   logic [0:31] OPB_DBus;
   logic        OPB_RNW;
   logic        OPB_select;
   logic        OPB_seqAddr;
   logic [0:31] Sl_DBus;
   logic        Sl_errAck;
   logic        Sl_retry;
   logic        Sl_toutSup;
   logic        Sl_xferAck;

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
   );

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
   );
endinterface
`default_nettype wire

// File: rtl/opb_register_simulink2ppc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_simulink2ppc_fifo
// Brief    : OPB slave FIFO carrying user-fabric words to the PowerPC.
//            Optional macro SNAP_FIFO_IRQ_EN adds the fill-level irq output.
// Revision : 1.0 - initial release
// ============================================================================
module opb_register_simulink2ppc_fifo #(
   parameter logic [31:0] C_BASEADDR        = 32'h0102_0000,
   parameter logic [31:0] C_HIGHADDR        = 32'h0102_00FF,
   parameter int          C_OPB_AWIDTH      = 32,
   parameter int          C_OPB_DWIDTH      = 32,
   parameter int          C_FIFO_DEPTH_LOG2 = 4,
   parameter int          C_IRQ_LEVEL       = 8,
   parameter              C_FAMILY          = "virtex6"
) (
   input  wire logic                                   OPB_Clk,
   input  wire logic                                   OPB_Rst_n,
   opb_register_simulink2ppc_fifo_if.slave             opb,
   input  wire logic [31:0]                            user_data_in,
   input  wire logic                                   user_we,
   output logic                                        user_full
`ifdef SNAP_FIFO_IRQ_EN
   ,
   output logic                                        irq
`endif
);

   localparam int                         c_depth     = 1 << C_FIFO_DEPTH_LOG2;
   localparam int                         c_cw        = C_FIFO_DEPTH_LOG2 + 1;
   localparam logic [c_cw-1:0]            c_full_cnt  = c_cw'(c_depth);
   localparam logic [C_OPB_AWIDTH-1:0]    c_off_data  = C_OPB_AWIDTH'(0);
   localparam logic [C_OPB_AWIDTH-1:0]    c_off_stat  = C_OPB_AWIDTH'(4);
   localparam logic [C_OPB_AWIDTH-1:0]    c_off_ctrl  = C_OPB_AWIDTH'(8);
   localparam int                         c_family_bits_unused = $bits(C_FAMILY);

   logic [31:0]                  r_mem [c_depth];
   logic [C_FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
   logic [C_FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
   logic [c_cw-1:0]              r_count;
   logic                         r_ovf;
   logic                         r_unf;
   logic                         r_full;
   logic                         r_ack;
   logic [C_OPB_DWIDTH-1:0]      r_dbus;

   logic [C_OPB_AWIDTH-1:0]      w_addr;
   logic [C_OPB_AWIDTH-1:0]      w_offset;
   logic                         w_hit;
   logic                         w_rd;
   logic                         w_wr;
   logic                         w_sel_data;
   logic                         w_sel_stat;
   logic                         w_sel_ctrl;
   logic                         w_empty;
   logic                         w_full;
   logic                         w_pop_req;
   logic                         w_pop;
   logic                         w_push;
   logic                         w_flush;
   logic                         w_clr;
   logic                         w_ovf_next;
   logic                         w_unf_next;
   logic [c_cw-1:0]              w_count_next;
   logic [C_OPB_DWIDTH-1:0]      w_status;
   logic [C_OPB_DWIDTH-1:0]      w_rdata;
   logic                         w_unused;

   assign w_addr   = opb.OPB_ABus;
   assign w_offset = w_addr - C_BASEADDR;

   // Blocking on r_ack keeps a select held through the ack cycle from re-hitting.
   assign w_hit = opb.OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR) && !r_ack;
   assign w_rd  = w_hit && opb.OPB_RNW;
   assign w_wr  = w_hit && !opb.OPB_RNW;

   assign w_sel_data = (w_offset == c_off_data);
   assign w_sel_stat = (w_offset == c_off_stat);
   assign w_sel_ctrl = (w_offset == c_off_ctrl);

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == c_full_cnt);
   assign w_pop_req = w_rd && w_sel_data;
   assign w_pop     = w_pop_req && !w_empty;

   // OPB_DBus is big-endian: index 31 carries numeric bit 0.
   assign w_flush = w_wr && w_sel_ctrl && opb.OPB_DBus[31];
   assign w_clr   = w_wr && w_sel_ctrl && opb.OPB_DBus[30];

   // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
   assign w_push     = user_we && !w_flush && (!w_full || w_pop);
   assign w_ovf_next = (user_we && !w_flush && w_full && !w_pop) || (r_ovf && !w_clr);
   assign w_unf_next = (w_pop_req && w_empty) || (r_unf && !w_clr);

   always_comb begin
      w_count_next = r_count;
      if (w_flush) begin
         w_count_next = '0;
      end else if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - 1'b1;
      end
   end

   always_comb begin
      w_status        = '0;
      w_status[31]    = r_ovf;
      w_status[30]    = r_unf;
`ifdef SNAP_FIFO_IRQ_EN
      w_status[29]    = irq;
`endif
      w_status[17]    = r_full;
      w_status[16]    = w_empty;
      w_status[15:0]  = 16'(r_count);
   end

   always_comb begin
      w_rdata = '0;
      if (w_sel_data) begin
         w_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
      end else if (w_sel_stat) begin
         w_rdata = w_status;
      end
   end

   always_ff @(posedge OPB_Clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= user_data_in;
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_full   <= 1'b0;
         r_ack    <= 1'b0;
         r_dbus   <= '0;
      end else begin
         r_ack    <= w_hit;
         r_dbus   <= w_rd ? w_rdata : '0;
         r_count  <= w_count_next;
         r_full   <= (w_count_next == c_full_cnt);
         r_ovf    <= w_ovf_next;
         r_unf    <= w_unf_next;
         if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

`ifdef SNAP_FIFO_IRQ_EN
   localparam logic [c_cw-1:0] c_irq_level = c_cw'(C_IRQ_LEVEL);

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         irq <= 1'b0;
      end else begin
         irq <= (w_count_next >= c_irq_level) || w_ovf_next;
      end
   end
`else
   localparam int c_irq_level_unused = C_IRQ_LEVEL;
`endif

   assign user_full      = r_full;
   assign opb.Sl_DBus    = r_dbus;
   assign opb.Sl_xferAck = r_ack;
   assign opb.Sl_errAck  = 1'b0;
   assign opb.Sl_retry   = 1'b0;
   assign opb.Sl_toutSup = 1'b0;

   assign w_unused = &{1'b0, opb.OPB_BE, opb.OPB_seqAddr, opb.OPB_DBus[0:29]};

endmodule
`default_nettype wire

// File: tb/tb_opb_register_simulink2ppc_fifo.sv
`default_nettype none
// Bench for opb_register_simulink2ppc_fifo: OPB register accesses against a
// queue scoreboard of pushed words plus fixed STATUS expectations.
module tb_opb_register_simulink2ppc_fifo;

   localparam logic [31:0] c_base = 32'h0102_0000;
   localparam logic [31:0] c_high = 32'h0102_00FF;
   localparam logic [31:0] c_data = c_base + 32'h0;
   localparam logic [31:0] c_stat = c_base + 32'h4;
   localparam logic [31:0] c_ctrl = c_base + 32'h8;
`ifdef SNAP_FIFO_IRQ_EN
   localparam logic [31:0] c_irqb = 32'h2000_0000;
`else
   localparam logic [31:0] c_irqb = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] user_data_in = '0;
   logic        user_we = 1'b0;
   logic        user_full;
`ifdef SNAP_FIFO_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] q_exp [$];

   opb_register_simulink2ppc_fifo_if bus ();

   opb_register_simulink2ppc_fifo dut (
      .OPB_Clk      (clk),
      .OPB_Rst_n    (rst_n),
      .opb          (bus),
      .user_data_in (user_data_in),
      .user_we      (user_we),
      .user_full    (user_full)
`ifdef SNAP_FIFO_IRQ_EN
      ,
      .irq          (irq)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic opb_access(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic acked);
      acked = 1'b0;
      rdata = '0;
      bus.OPB_ABus   = addr;
      bus.OPB_RNW    = rnw;
      bus.OPB_DBus   = wdata;
      bus.OPB_select = 1'b1;
      for (int i = 0; i < 4 && !acked; i++) begin
         @(posedge clk); #1;
         if (bus.Sl_xferAck) begin
            acked = 1'b1;
            rdata = bus.Sl_DBus;
         end
      end
      bus.OPB_select = 1'b0;
      bus.OPB_DBus   = '0;
   endtask

   task automatic reg_read(input logic [31:0] addr, output logic [31:0] rdata);
      logic acked;
      opb_access(addr, 1'b1, '0, rdata, acked);
      if (!acked) begin
         checks++; errors++;
         $display("FAIL read_timeout addr=%h: got no ack, required ack", addr);
      end
   endtask

   task automatic reg_write(input logic [31:0] addr, input logic [31:0] wdata);
      logic acked;
      logic [31:0] dummy;
      opb_access(addr, 1'b0, wdata, dummy, acked);
      if (!acked) begin
         checks++; errors++;
         $display("FAIL write_timeout addr=%h: got no ack, required ack", addr);
      end
   endtask

   task automatic push(input logic [31:0] word);
      user_data_in = word;
      user_we      = 1'b1;
      if (q_exp.size() < 16) q_exp.push_back(word);
      @(posedge clk); #1;
      user_we = 1'b0;
   endtask

   task automatic check_status(input string name, input logic [31:0] exp);
      logic [31:0] got;
      reg_read(c_stat, got);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: STATUS got %h, required %h", name, got, exp);
      end
   endtask

   task automatic pop_check(input string name);
      logic [31:0] got;
      logic [31:0] exp;
      exp = (q_exp.size() > 0) ? q_exp.pop_front() : 32'h0;
      reg_read(c_data, got);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: DATA got %h, required %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0 || user_full !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b dbus=%h full=%b, required 0 0 0",
                  bus.Sl_xferAck, bus.Sl_DBus, user_full);
      end
`ifdef SNAP_FIFO_IRQ_EN
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b, required 0", irq);
      end
`endif
      check_status("reset_status", 32'h0001_0000);
   endtask

   task automatic test_basic();
      push(32'h11); push(32'h22); push(32'h33);
      check_status("basic_count3", 32'h0000_0003);
      for (int i = 0; i < 3; i++) pop_check("basic_data");
      check_status("basic_empty", 32'h0001_0000);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 17; i++) push(32'h100 + 32'(i));
      checks++;
      if (user_full !== 1'b1) begin
         errors++;
         $display("FAIL ovf_user_full: got %b, required 1", user_full);
      end
      check_status("ovf_status", 32'h8002_0010 | c_irqb);
      reg_write(c_ctrl, 32'h2);
      check_status("ovf_cleared", 32'h0002_0010 | c_irqb);
      for (int i = 0; i < 16; i++) pop_check("ovf_drain");
      check_status("ovf_drained", 32'h0001_0000);
   endtask

   task automatic test_underflow();
      pop_check("unf_data_zero");
      check_status("unf_status", 32'h4001_0000);
      reg_write(c_ctrl, 32'h2);
      check_status("unf_cleared", 32'h0001_0000);
   endtask

   task automatic test_full_push_pop();
      logic [31:0] got;
      logic [31:0] exp;
      for (int i = 0; i < 16; i++) push(32'h200 + 32'(i));
      exp = q_exp.pop_front();
      q_exp.push_back(32'hABCD_0001);
      bus.OPB_ABus = c_data; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
      user_data_in = 32'hABCD_0001; user_we = 1'b1;
      @(posedge clk); #1;
      user_we = 1'b0; bus.OPB_select = 1'b0;
      got = bus.Sl_DBus;
      checks++;
      if (bus.Sl_xferAck !== 1'b1 || got !== exp) begin
         errors++;
         $display("FAIL fpp_pop: ack=%b data=%h, required ack=1 data=%h", bus.Sl_xferAck, got, exp);
      end
      check_status("fpp_count16", 32'h0002_0010 | c_irqb);
      for (int i = 0; i < 16; i++) pop_check("fpp_drain");
      check_status("fpp_empty", 32'h0001_0000);
   endtask

   task automatic test_select_hold();
      int acks;
      logic [31:0] got;
      logic acked;
      acks = 0;
      bus.OPB_ABus = c_stat; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (bus.Sl_xferAck) acks++;
         if (i == 1) bus.OPB_select = 1'b0;
      end
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL hold_one_ack: got %0d acks, required 1", acks);
      end
      acks = 0;
      bus.OPB_ABus = c_high + 32'h4; bus.OPB_select = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (bus.Sl_xferAck) acks++;
      end
      bus.OPB_ABus = c_base - 32'h4;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (bus.Sl_xferAck) acks++;
      end
      bus.OPB_select = 1'b0;
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL outside_window: got %0d acks, required 0", acks);
      end
      opb_access(c_high, 1'b1, '0, got, acked);
      checks++;
      if (acked !== 1'b1 || got !== 32'h0) begin
         errors++;
         $display("FAIL highaddr_read: ack=%b data=%h, required ack=1 data=0", acked, got);
      end
      push(32'h55);
      opb_access(c_data, 1'b0, 32'hFFFF_FFFF, got, acked);
      checks++;
      if (acked !== 1'b1) begin
         errors++;
         $display("FAIL data_write_ack: got %b, required 1", acked);
      end
      reg_read(c_ctrl, got);
      checks++;
      if (got !== 32'h0) begin
         errors++;
         $display("FAIL ctrl_read: got %h, required 0", got);
      end
      check_status("data_write_ignored", 32'h0000_0001);
      pop_check("data_write_drain");
   endtask

   task automatic test_flush_push();
      logic acked;
      logic [31:0] dummy;
      for (int i = 0; i < 5; i++) push(32'h300 + 32'(i));
      user_data_in = 32'hDEAD_BEEF; user_we = 1'b1;
      bus.OPB_ABus = c_ctrl; bus.OPB_RNW = 1'b0; bus.OPB_DBus = 32'h1; bus.OPB_select = 1'b1;
      @(posedge clk); #1;
      user_we = 1'b0; bus.OPB_select = 1'b0; bus.OPB_DBus = '0;
      q_exp.delete();
      check_status("flush_status", 32'h0001_0000);
      push(32'h77);
      pop_check("flush_then_push");
      opb_access(c_stat, 1'b1, '0, dummy, acked);
   endtask

`ifdef SNAP_FIFO_IRQ_EN
   task automatic test_irq();
      for (int i = 0; i < 7; i++) push(32'h400 + 32'(i));
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_below_level: got %b, required 0", irq);
      end
      push(32'h407);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_at_level: got %b, required 1", irq);
      end
      reg_write(c_ctrl, 32'h1);
      q_exp.delete();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_after_flush: got %b, required 0", irq);
      end
      check_status("irq_flush_status", 32'h0001_0000);
   endtask
`endif

   task automatic test_reset_mid();
      push(32'h9); push(32'hA);
      bus.OPB_ABus = c_stat; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
      @(posedge clk); #1;
      bus.OPB_select = 1'b0;
      checks++;
      if (bus.Sl_xferAck !== 1'b1) begin
         errors++;
         $display("FAIL midrst_ack_before: got %b, required 1", bus.Sl_xferAck);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0) begin
         errors++;
         $display("FAIL midrst_async_drop: ack=%b dbus=%h, required 0 0", bus.Sl_xferAck, bus.Sl_DBus);
      end
      q_exp.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_status("midrst_status", 32'h0001_0000);
   endtask

   initial begin
      bus.OPB_ABus = '0; bus.OPB_BE = 4'hF; bus.OPB_DBus = '0;
      bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_overflow();
      test_underflow();
      test_full_push_pop();
      test_select_hold();
      test_flush_push();
`ifdef SNAP_FIFO_IRQ_EN
      test_irq();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
